// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM/WB portion of the pipeline.
package mips_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_LH   = 3'd3,
    MEM_LHU  = 3'd4,
    MEM_LW   = 3'd5
  } mem_op_e;

  // Architectural zero register; writes to it are discarded.
  localparam int ZERO_REG = '0;

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: picks the addressed byte/halfword out of
// the raw little-endian memory word, extends it, and flags misaligned loads.
module load_align
  import mips_pkg::*;
(
  input  mem_op_e     mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  input  logic [31:0] alu_out,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend according to the load type.
  always_comb begin
    byte_sel = raw[{off, 3'b000} +: 8];
    half_sel = off[1] ? raw[31:16] : raw[15:0];
    data     = alu_out;
    misalign = 1'b0;
    case (mem_op)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'h0, byte_sel};
      MEM_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = off[0];
      end
      MEM_LHU: begin
        data     = {16'h0, half_sel};
        misalign = off[0];
      end
      MEM_LW: begin
        data     = raw;
        misalign = (off != 2'b00);
      end
      default: data = alu_out;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM->WB pipeline register with stall/flush, r0 write suppression and a
// retired-instruction counter. Load alignment is done ahead of the register.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  mem_op_e           mem_op_m,
  input  logic [31:0]       alu_out_m,
  input  logic [31:0]       read_data_m,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [31:0]       pc_m,
  input  logic              stall_w,
  input  logic              flush_w,
  output logic [31:0]       result_w,
  output logic [REG_AW-1:0] write_reg_w,
  output logic              reg_write_w,
  output logic              valid_w,
  output logic              misalign_w,
  output logic [31:0]       pc_w,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [31:0] aligned_data;
  logic        misalign_m;
  logic        reg_write_d;

  load_align u_load_align (
    .mem_op   (mem_op_m),
    .off      (alu_out_m[1:0]),
    .raw      (read_data_m),
    .alu_out  (alu_out_m),
    .data     (aligned_data),
    .misalign (misalign_m)
  );

  // Write enable is resolved before the register so the WB port is a flop output.
  assign reg_write_d = valid_m & reg_write_m & ~misalign_m &
                       (write_reg_m != REG_AW'(ZERO_REG));

  // Pipeline register: flush beats stall, stall beats capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_w    <= '0;
      write_reg_w <= '0;
      reg_write_w <= 1'b0;
      valid_w     <= 1'b0;
      misalign_w  <= 1'b0;
      pc_w        <= '0;
    end else if (flush_w) begin
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
      misalign_w  <= 1'b0;
    end else if (!stall_w) begin
      result_w    <= aligned_data;
      write_reg_w <= write_reg_m;
      reg_write_w <= reg_write_d;
      valid_w     <= valid_m;
      misalign_w  <= misalign_m;
      pc_w        <= pc_m;
    end
  end

  // Count an instruction as it leaves WB; a flush in that same cycle still counts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (valid_w && !stall_w) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: each driven cycle pushes the expected
// W-stage state, which is popped and compared after the following edge.
module tb_writeback_stage;
  import mips_pkg::*;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              mis;
    logic [31:0]       result;
    logic [REG_AW-1:0] wreg;
    logic [31:0]       pc;
    logic [CNT_W-1:0]  cnt;
  } wb_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_m = 1'b0;
  logic              reg_write_m = 1'b0;
  mem_op_e           mem_op_m = MEM_NONE;
  logic [31:0]       alu_out_m = '0;
  logic [31:0]       read_data_m = '0;
  logic [REG_AW-1:0] write_reg_m = '0;
  logic [31:0]       pc_m = '0;
  logic              stall_w = 1'b0;
  logic              flush_w = 1'b0;
  logic [31:0]       result_w;
  logic [REG_AW-1:0] write_reg_w;
  logic              reg_write_w;
  logic              valid_w;
  logic              misalign_w;
  logic [31:0]       pc_w;
  logic [CNT_W-1:0]  retired_cnt;

  int  n_checks = 0;
  int  n_fail   = 0;
  wb_t cur      = '0;
  wb_t sb_q[$];

  writeback_stage #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_m     (valid_m),
    .reg_write_m (reg_write_m),
    .mem_op_m    (mem_op_m),
    .alu_out_m   (alu_out_m),
    .read_data_m (read_data_m),
    .write_reg_m (write_reg_m),
    .pc_m        (pc_m),
    .stall_w     (stall_w),
    .flush_w     (flush_w),
    .result_w    (result_w),
    .write_reg_w (write_reg_w),
    .reg_write_w (reg_write_w),
    .valid_w     (valid_w),
    .misalign_w  (misalign_w),
    .pc_w        (pc_w),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference alignment written with shifts rather than lane cases.
  function automatic logic [31:0] model_data(input logic [2:0] op, input logic [31:0] alu,
                                              input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * alu[1:0])) & 32'hFF;
    h = (rd >> (16 * alu[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b ^ 32'h80) - 32'h80;
      3'd2:    return b;
      3'd3:    return (h ^ 32'h8000) - 32'h8000;
      3'd4:    return h;
      3'd5:    return rd;
      default: return alu;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] op, input logic [1:0] off);
    if (op == 3'd3 || op == 3'd4) return off[0];
    if (op == 3'd5) return off != 2'b00;
    return 1'b0;
  endfunction

  task automatic compare_w(input string pfx);
    wb_t e;
    if (sb_q.size() == 0) begin
      check({pfx, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({pfx, ".valid"},  {31'b0, valid_w},     {31'b0, e.valid});
    check({pfx, ".rw"},     {31'b0, reg_write_w}, {31'b0, e.rw});
    check({pfx, ".mis"},    {31'b0, misalign_w},  {31'b0, e.mis});
    check({pfx, ".result"}, result_w,             e.result);
    check({pfx, ".wreg"},   32'(write_reg_w),     32'(e.wreg));
    check({pfx, ".pc"},     pc_w,                 e.pc);
    check({pfx, ".cnt"},    32'(retired_cnt),     32'(e.cnt));
    cur = e;
  endtask

  task automatic drive(input string tag, input logic v, input logic rw, input logic [2:0] op,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [REG_AW-1:0] wreg, input logic [31:0] pc,
                       input logic stall, input logic flush);
    wb_t n;
    @(negedge clk);
    valid_m = v; reg_write_m = rw; mem_op_m = mem_op_e'(op); alu_out_m = alu;
    read_data_m = rd; write_reg_m = wreg; pc_m = pc; stall_w = stall; flush_w = flush;
    n = cur;
    if (cur.valid && !stall) n.cnt = cur.cnt + 1'b1;
    if (flush) begin
      n.valid = 1'b0; n.rw = 1'b0; n.mis = 1'b0;
    end else if (!stall) begin
      n.valid  = v;
      n.mis    = model_mis(op, alu[1:0]);
      n.rw     = v & rw & ~n.mis & (wreg != 0);
      n.result = model_data(op, alu, rd);
      n.wreg   = wreg;
      n.pc     = pc;
    end
    sb_q.push_back(n);
    @(posedge clk);
    #1;
    compare_w(tag);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, ".valid"},  {31'b0, valid_w},     32'd0);
    check({pfx, ".rw"},     {31'b0, reg_write_w}, 32'd0);
    check({pfx, ".mis"},    {31'b0, misalign_w},  32'd0);
    check({pfx, ".result"}, result_w,             32'd0);
    check({pfx, ".wreg"},   32'(write_reg_w),     32'd0);
    check({pfx, ".pc"},     pc_w,                 32'd0);
    check({pfx, ".cnt"},    32'(retired_cnt),     32'd0);
  endtask

  // Reset mid-cycle, clear the model, release on the next falling edge with idle inputs.
  task automatic mid_reset(input string pfx);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero(pfx);
    cur = '0;
    sb_q.delete();
    @(negedge clk);
    valid_m = 0; reg_write_m = 0; mem_op_m = MEM_NONE; alu_out_m = '0;
    read_data_m = '0; write_reg_m = '0; pc_m = '0; stall_w = 0; flush_w = 0;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    check_all_zero("rst0");
    @(negedge clk);
    rst = 1'b0;

    drive("lb",   1, 1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 5'd3, 32'h100, 0, 0);
    check("lb.value", result_w, 32'hFFFF_FF80);
    drive("lbu",  1, 1, 3'd2, 32'h0000_1003, 32'h80FF_7F01, 5'd4, 32'h104, 0, 0);
    check("lbu.value", result_w, 32'h0000_0080);
    drive("lh2",  1, 1, 3'd3, 32'h0000_2002, 32'h8001_1234, 5'd5, 32'h108, 0, 0);
    check("lh2.value", result_w, 32'hFFFF_8001);
    drive("lh1",  1, 1, 3'd3, 32'h0000_2001, 32'h8001_1234, 5'd6, 32'h10C, 0, 0);
    check("lh1.mis", {31'b0, misalign_w}, 32'd1);
    check("lh1.rw",  {31'b0, reg_write_w}, 32'd0);
    drive("lhu0", 1, 1, 3'd4, 32'h0000_2000, 32'h8001_F234, 5'd7, 32'h110, 0, 0);
    drive("lw0",  1, 1, 3'd5, 32'h0000_3000, 32'hDEAD_BEEF, 5'd8, 32'h114, 0, 0);
    drive("lw2",  1, 1, 3'd5, 32'h0000_3002, 32'hDEAD_BEEF, 5'd9, 32'h118, 0, 0);
    drive("r0",   1, 1, 3'd0, 32'h1234_5678, 32'h0,        5'd0, 32'h11C, 0, 0);
    check("r0.valid", {31'b0, valid_w}, 32'd1);
    check("r0.rw",    {31'b0, reg_write_w}, 32'd0);

    // Stall with changing M inputs, then release, then flush+stall bubble.
    drive("st_a", 1, 1, 3'd0, 32'hAAAA_0000, 32'h0, 5'd10, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++)
      drive("st_hold", 1, 1, 3'd1, 32'h5555_0000 + i, 32'h1111_1111 * i, 5'(11 + i),
            32'h300 + i, 1, 0);
    check("st_hold.result", result_w, 32'hAAAA_0000);
    drive("st_rel", 1, 1, 3'd0, 32'hBBBB_0000, 32'h0, 5'd12, 32'h204, 0, 0);
    drive("fl_st",  1, 1, 3'd0, 32'hCCCC_0000, 32'h0, 5'd13, 32'h208, 1, 1);
    check("fl_st.valid", {31'b0, valid_w}, 32'd0);
    drive("fl_only", 1, 1, 3'd0, 32'hDDDD_0000, 32'h0, 5'd14, 32'h20C, 0, 0);
    drive("fl_cnt",  0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h210, 0, 1);

    // Reset mid-stall with a valid instruction in WB.
    drive("pre_rst", 1, 1, 3'd0, 32'h7777_0000, 32'h0, 5'd15, 32'h400, 0, 0);
    drive("stl_rst", 1, 1, 3'd0, 32'h8888_0000, 32'h0, 5'd16, 32'h404, 1, 0);
    mid_reset("rst_mid");

    // Counter wrap: 17 back-to-back retirements from zero.
    for (int i = 0; i < 17; i++)
      drive("wrap", 1, 1, 3'd0, 32'(i), 32'h0, 5'd1, 32'h500 + 4 * i, 0, 0);
    drive("wrap_end", 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0);
    check("wrap.cnt", 32'(retired_cnt), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++)
      drive("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom_range(0, 5)),
            $urandom, $urandom, 5'($urandom), $urandom,
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
